// File: rtl/lc3b_types.sv
// Shared type definitions for the execute-stage algebra unit.
package lc3b_types;

    // Operation select as presented on the op input.
    typedef enum logic [1:0] {
        ALG_MULU = 2'b00,
        ALG_MULS = 2'b01,
        ALG_DIVU = 2'b10,
        ALG_DIVS = 2'b11
    } lc3b_alg_op;

    // Sequencer states of the iterative engine.
    typedef enum logic [1:0] {
        ALG_IDLE = 2'b00,
        ALG_CALC = 2'b01,
        ALG_FIX  = 2'b10,
        ALG_DONE = 2'b11
    } lc3b_alg_state;

endpackage

// File: rtl/alg_iter_step.sv
// One iteration of the shared multiply/divide datapath.
// MUL: shift-add on {product_hi, multiplier} with the multiplicand in operand_i.
// DIV: restoring step on {remainder, dividend/quotient} with the divisor in operand_i.
module alg_iter_step #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Compute both step flavours and select by operation class.
    always_comb begin
        // Add the multiplicand when the current multiplier bit is set; carry lands in bit WIDTH.
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Remainder shifted left with the next dividend bit brought in from below.
        rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
        // Since remainder < divisor, the top bit of this WIDTH+1 bit difference is the borrow.
        diff    = rem_sh - {1'b0, operand_i};
        q_bit_o = ~diff[WIDTH];
        if (is_div_i) begin
            acc_o = {(q_bit_o ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], q_bit_o};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alg_unit_seq.sv
// Iterative one-bit-per-cycle multiply/divide engine for the execute stage.
// Handshake: start is sampled only while idle (busy low) and only when flush is low;
// done pulses for one cycle and hi_bits/lo_bits/div_by_zero are valid from that cycle
// and hold until the next completed operation. flush aborts CALC/FIX without a done.
module alg_unit_seq #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_bits,
    output logic [WIDTH-1:0] lo_bits
);

    import lc3b_types::*;

    lc3b_alg_state      state_q;
    lc3b_alg_op         op_q;
    logic [CNTW-1:0]    cnt_q;
    logic               sign_q;
    logic               sign_r;
    logic               dbz_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               busy_q;
    logic               done_q;
    logic               div_by_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    lc3b_alg_op         op_in;
    logic               in_div;
    logic               in_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div;
    logic [2*WIDTH-1:0] acc_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign is_div = (op_q == ALG_DIVU) || (op_q == ALG_DIVS);

    alg_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .is_div_i  (is_div),
        .acc_o     (acc_next),
        .q_bit_o   (q_bit)
    );

    // Decode the incoming request and form operand magnitudes for signed modes.
    always_comb begin
        op_in     = lc3b_alg_op'(op);
        in_div    = (op_in == ALG_DIVU) || (op_in == ALG_DIVS);
        in_signed = (op_in == ALG_MULS) || (op_in == ALG_DIVS);
        mag_a     = (in_signed && opA[WIDTH-1]) ? -opA : opA;
        mag_b     = (in_signed && opB[WIDTH-1]) ? -opB : opB;
    end

    // Sign correction applied when leaving FIX; divide-by-zero bypasses it entirely.
    always_comb begin
        prod = acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (op_q == ALG_MULS && sign_q) prod = -acc_q;
        if (op_q == ALG_DIVS && sign_q) quo  = -acc_q[WIDTH-1:0];
        if (op_q == ALG_DIVS && sign_r) rem  = -acc_q[2*WIDTH-1:WIDTH];
        if (dbz_q) begin
            fix_hi = acc_q[WIDTH-1:0];
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = rem;
            fix_lo = quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // Sequencer with registered busy/done/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ALG_IDLE;
            op_q          <= ALG_MULU;
            cnt_q         <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            dbz_q         <= 1'b0;
            opnd_q        <= '0;
            acc_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ALG_IDLE: begin
                    if (start && !flush) begin
                        op_q          <= op_in;
                        sign_q        <= in_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        sign_r        <= in_signed & opA[WIDTH-1];
                        div_by_zero_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (in_div && opB == '0) begin
                            // Divide by zero: keep the raw dividend and skip iterating.
                            dbz_q   <= 1'b1;
                            acc_q   <= {{WIDTH{1'b0}}, opA};
                            state_q <= ALG_FIX;
                        end else begin
                            dbz_q   <= 1'b0;
                            opnd_q  <= in_div ? mag_b : mag_a;
                            acc_q   <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                            cnt_q   <= CNTW'(WIDTH);
                            state_q <= ALG_CALC;
                        end
                    end
                end
                ALG_CALC: begin
                    if (flush) begin
                        state_q <= ALG_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNTW'(1)) state_q <= ALG_FIX;
                    end
                end
                ALG_FIX: begin
                    if (flush) begin
                        state_q <= ALG_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q          <= fix_hi;
                        lo_q          <= fix_lo;
                        div_by_zero_q <= dbz_q;
                        done_q        <= 1'b1;
                        state_q       <= ALG_DONE;
                    end
                end
                default: begin
                    // DONE: results already committed, a late flush changes nothing.
                    state_q <= ALG_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi_bits     = hi_q;
    assign lo_bits     = lo_q;

endmodule

// File: tb/tb_alg_unit_seq.sv
// Bench for alg_unit_seq: cycle-level reference model, per-cycle compare, result scoreboard.
module tb_alg_unit_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi_bits;
    logic [W-1:0] lo_bits;

    int total = 0;
    int bad   = 0;

    logic [2*W:0] exp_q[$];

    // model state
    int           m_cnt;
    int           m_len;
    logic         m_done;
    logic         m_dbz;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [2*W:0] m_pend;
    logic [2*W:0] sb_e;

    alg_unit_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .flush       (flush),
        .op          (op),
        .opA         (opA),
        .opB         (opB),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_bits     (hi_bits),
        .lo_bits     (lo_bits)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Reference result {dbz, hi, lo} from plain arithmetic.
    function automatic logic [2*W:0] ref_calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        int     q;
        int     r;
        p = 0; q = 0; r = 0;
        if (o == 2'd0) begin
            p = longint'(a) * longint'(b);
            return {1'b0, p[2*W-1:0]};
        end else if (o == 2'd1) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {1'b0, p[2*W-1:0]};
        end else if (b == '0) begin
            return {1'b1, a, {W{1'b1}}};
        end else if (o == 2'd2) begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end else begin
            q = int'($signed(a)) / int'($signed(b));
            r = int'($signed(a)) % int'($signed(b));
        end
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: cycles since acceptance, done at the spec latency.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_len  <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            exp_q.delete();
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start && !flush) begin
                    m_pend <= ref_calc(op, opA, opB);
                    exp_q.push_back(ref_calc(op, opA, opB));
                    m_len  <= (op[1] && opB == '0) ? 2 : W + 2;
                    m_cnt  <= 1;
                    m_dbz  <= 1'b0;
                end
            end else if (m_cnt == m_len) begin
                m_cnt <= 0;
            end else if (flush) begin
                m_cnt <= 0;
                void'(exp_q.pop_back());
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_len) begin
                    m_done <= 1'b1;
                    {m_dbz, m_hi, m_lo} <= m_pend;
                end
            end
        end
    end

    // Per-cycle compare plus scoreboard drain on done.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, m_cnt != 0);
            chk("done", done, m_done);
            chk("hi", hi_bits, m_hi);
            chk("lo", lo_bits, m_lo);
            chk("dbz", div_by_zero, m_dbz);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got done with no expected result");
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_result", {div_by_zero, hi_bits, lo_bits}, sb_e);
                end
            end
        end
    end

    // driver: directed op with literal expectations
    task automatic run_dir(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int c;
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("%s_latency", name), c, lat);
        chk($sformatf("%s_hi", name), hi_bits, eh);
        chk($sformatf("%s_lo", name), lo_bits, el);
        chk($sformatf("%s_dbz", name), div_by_zero, ed);
        @(negedge clk);
    endtask

    // driver: op with start/operand noise in cycles 3-17
    task automatic run_noise(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int           done_at;
        logic [2*W:0] e;
        e = ref_calc(o, a, b);
        done_at = 0;
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (done === 1'b1 && done_at == 0) done_at = c;
            if (c >= 3 && c <= 17) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                opA   = W'($urandom);
                opB   = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk("noise_latency", done_at, 18);
        chk("noise_result", {div_by_zero, hi_bits, lo_bits}, e);
    endtask

    // driver: random op with random flush and ignored starts
    task automatic run_rand();
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        o = 2'($urandom_range(0, 3));
        a = W'($urandom);
        b = W'($urandom);
        case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 16'h8000; b = 16'hFFFF; end
            2: b = 16'h0001;
            default: ;
        endcase
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        flush = ($urandom_range(0, 9) == 0);
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (m_cnt == 0) begin
                start = 1'b0;
                flush = 1'b0;
                break;
            end
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 39) == 0);
            opA   = W'($urandom);
            opB   = W'($urandom);
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi_bits, 0);
        chk("rst_lo", lo_bits, 0);
        #1 reset = 1'b0;

        // pin the model against hand-computed values
        chk("model_mulu", ref_calc(2'd0, 16'h1234, 16'h0100), {1'b0, 16'h0012, 16'h3400});
        chk("model_divs", ref_calc(2'd3, 16'hFFF9, 16'h0002), {1'b0, 16'hFFFF, 16'hFFFD});
        chk("model_ovf", ref_calc(2'd3, 16'h8000, 16'hFFFF), {1'b0, 16'h0000, 16'h8000});

        run_dir("mulu", 2'd0, 16'h1234, 16'h0100, 18, 16'h0012, 16'h3400, 1'b0);
        run_dir("muls", 2'd1, 16'hFFFE, 16'h0003, 18, 16'hFFFF, 16'hFFFA, 1'b0);
        run_dir("mulu2", 2'd0, 16'hFFFE, 16'h0003, 18, 16'h0002, 16'hFFFA, 1'b0);
        run_dir("divs", 2'd3, 16'hFFF9, 16'h0002, 18, 16'hFFFF, 16'hFFFD, 1'b0);
        run_dir("divs_ovf", 2'd3, 16'h8000, 16'hFFFF, 18, 16'h0000, 16'h8000, 1'b0);
        run_dir("dbz", 2'd2, 16'h1234, 16'h0000, 2, 16'h1234, 16'hFFFF, 1'b1);

        // flush in cycle 5: no done, outputs held, dbz cleared by the accept
        @(negedge clk);
        op = 2'd0; opA = 16'h0003; opB = 16'h0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flush_dbz_cleared", div_by_zero, 0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi_bits, 16'h1234);
        chk("flush_lo", lo_bits, 16'hFFFF);
        run_dir("after_flush", 2'd0, 16'h0003, 16'h0005, 18, 16'h0000, 16'h000F, 1'b0);

        // flush & start together in idle
        @(negedge clk);
        op = 2'd0; opA = 16'h0007; opB = 16'h0007; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);
        repeat (2) @(negedge clk);

        run_noise(2'd0, 16'hABCD, 16'h1357);
        run_noise(2'd3, 16'h8123, 16'h0077);

        // async reset in cycle 9
        @(negedge clk);
        op = 2'd1; opA = 16'h1111; opB = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_hi", hi_bits, 0);
        chk("areset_lo", lo_bits, 0);
        chk("areset_dbz", div_by_zero, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        run_dir("post_reset", 2'd2, 16'h1234, 16'h0010, 18, 16'h0004, 16'h0123, 1'b0);

        repeat (60) run_rand();
        repeat (25) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
